// File: rtl/nhap_state.sv
// nhap_state: button-driven entry of a bit string followed by a 4-bit search pattern.
//
// Ports
//   clk        single clock, all state updates on its rising edge
//   reset      asynchronous active-low reset
//   bit_in     data bit (switch level) captured on a push event
//   push_btn   level button, each rising edge enters one bit
//   next_btn   level button, a rising edge ends string entry
//   roll_back  level button, a rising edge clears everything and restarts entry
//   stringo    entered string, bit 0 entered first, unwritten bits stay 0
//   counter    number of valid bits in stringo
//   in_comp    search pattern, entered MSB first
//   ready      high while both string and pattern are complete
//   full       sticky: push attempted with the string already at capacity
//   err        sticky: next pressed with fewer than 4 string bits
//   state      current phase for display: 0 string, 1 pattern, 2 ready
module nhap_state #(
  parameter int MAX_LEN = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bit_in,
  input  logic               push_btn,
  input  logic               next_btn,
  input  logic               roll_back,
  output logic [0:MAX_LEN-1] stringo,
  output logic [7:0]         counter,
  output logic [3:0]         in_comp,
  output logic               ready,
  output logic               full,
  output logic               err,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_STR   = 2'd0,
    S_PAT   = 2'd1,
    S_READY = 2'd2
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_LEN);

  state_t             state_q, state_d;
  logic               push_q, next_q, roll_q;
  logic               push_ev, next_ev, roll_ev;
  logic [2:0]         pidx, pidx_d;
  logic [0:MAX_LEN-1] str_d;
  logic [7:0]         cnt_d;
  logic [3:0]         pat_d;
  logic               ready_d, full_d, err_d;

  // One event per press: the first edge at which the button is seen high after low.
  assign push_ev = push_btn  & ~push_q;
  assign next_ev = next_btn  & ~next_q;
  assign roll_ev = roll_back & ~roll_q;

  assign state = state_q;

  always_comb begin
    state_d = state_q;
    str_d   = stringo;
    cnt_d   = counter;
    pat_d   = in_comp;
    pidx_d  = pidx;
    ready_d = ready;
    full_d  = full;
    err_d   = err;

    if (roll_ev) begin
      state_d = S_STR;
      str_d   = '0;
      cnt_d   = '0;
      pat_d   = '0;
      pidx_d  = '0;
      ready_d = 1'b0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_STR: begin
          // next wins over a coincident push; the push is dropped
          if (next_ev) begin
            if (counter >= 8'd4) begin
              state_d = S_PAT;
              pidx_d  = '0;
            end else begin
              err_d = 1'b1;
            end
          end else if (push_ev) begin
            if (counter < MAX_CNT) begin
              for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (i == 32'(counter)) str_d[i] = bit_in;
              end
              cnt_d = counter + 8'd1;
            end else begin
              full_d = 1'b1;
            end
          end
        end
        S_PAT: begin
          if (push_ev) begin
            pat_d[2'd3 - pidx[1:0]] = bit_in;
            pidx_d = pidx + 3'd1;
            if (pidx == 3'd3) begin
              state_d = S_READY;
              ready_d = 1'b1;
            end
          end
        end
        S_READY: begin
        end
        default: state_d = S_STR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_STR;
      stringo <= '0;
      counter <= '0;
      in_comp <= '0;
      pidx    <= '0;
      ready   <= 1'b0;
      full    <= 1'b0;
      err     <= 1'b0;
      push_q  <= 1'b0;
      next_q  <= 1'b0;
      roll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stringo <= str_d;
      counter <= cnt_d;
      in_comp <= pat_d;
      pidx    <= pidx_d;
      ready   <= ready_d;
      full    <= full_d;
      err     <= err_d;
      push_q  <= push_btn;
      next_q  <= next_btn;
      roll_q  <= roll_back;
    end
  end

endmodule

// File: tb/tb_nhap_state.sv
module tb_nhap_state;

  localparam int ML = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          bit_in = 1'b0;
  logic          push_btn = 1'b0;
  logic          next_btn = 1'b0;
  logic          roll_back = 1'b0;
  logic [0:ML-1] stringo;
  logic [7:0]    counter;
  logic [3:0]    in_comp;
  logic          ready;
  logic          full;
  logic          err;
  logic [1:0]    state;

  nhap_state #(.MAX_LEN(ML)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .push_btn(push_btn),
    .next_btn(next_btn), .roll_back(roll_back), .stringo(stringo),
    .counter(counter), .in_comp(in_comp), .ready(ready), .full(full),
    .err(err), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the string as a queue of bits, the pattern as an integer
  // built by shifting, and a phase number 0/1/2.
  bit m_q[$];
  int m_phase = 0;
  int m_pat = 0;
  int m_pcnt = 0;
  bit m_full = 0;
  bit m_err = 0;
  bit pp = 0, pn = 0, pr = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_phase = 0;
    m_pat = 0;
    m_pcnt = 0;
    m_full = 0;
    m_err = 0;
  endtask

  task automatic model_edge(input bit p, input bit n, input bit r, input bit b);
    bit pe, ne, re;
    pe = p & ~pp;
    ne = n & ~pn;
    re = r & ~pr;
    pp = p; pn = n; pr = r;
    if (re) begin
      model_clear();
    end else if (m_phase == 0) begin
      if (ne) begin
        if (m_q.size() >= 4) begin
          m_phase = 1;
          m_pcnt = 0;
        end else begin
          m_err = 1;
        end
      end else if (pe) begin
        if (m_q.size() < ML) m_q.push_back(b);
        else m_full = 1;
      end
    end else if (m_phase == 1) begin
      if (pe) begin
        m_pat = m_pat * 2 + int'(b);
        m_pcnt++;
        if (m_pcnt == 4) m_phase = 2;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [0:ML-1] es;
    logic [3:0]    ep;
    es = '0;
    for (int i = 0; i < m_q.size(); i++) es[i] = m_q[i];
    ep = 4'((m_pat << (4 - m_pcnt)) & 15);
    chk({tag, ".stringo"}, 256'(stringo), 256'(es));
    chk({tag, ".counter"}, 256'(counter), 256'(m_q.size()));
    chk({tag, ".in_comp"}, 256'(in_comp), 256'(ep));
    chk({tag, ".ready"},   256'(ready),   256'(m_phase == 2));
    chk({tag, ".full"},    256'(full),    256'(m_full));
    chk({tag, ".err"},     256'(err),     256'(m_err));
    chk({tag, ".state"},   256'(state),   256'(m_phase));
  endtask

  task automatic step(input bit p, input bit n, input bit r, input bit b, input string tag);
    @(negedge clk);
    push_btn = p; next_btn = n; roll_back = r; bit_in = b;
    @(posedge clk);
    model_edge(p, n, r, b);
    #1 compare_all(tag);
  endtask

  task automatic push_bit(input bit b);
    step(1, 0, 0, b, "push");
    step(0, 0, 0, b, "push_rel");
  endtask

  task automatic press_next();
    step(0, 1, 0, 0, "next");
    step(0, 0, 0, 0, "next_rel");
  endtask

  task automatic press_roll();
    step(0, 0, 1, 0, "roll");
    step(0, 0, 0, 0, "roll_rel");
  endtask

  logic [0:19]   seq20;
  logic [0:ML-1] ones;
  int            base;

  initial begin
    // Reset state, checked without any clock edge dependence
    #1 compare_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // 20-bit string, then the 4-bit pattern 1011
    seq20 = 20'b1010_1011_0110_1111_0010;
    for (int i = 0; i < 20; i++) push_bit(seq20[i]);
    press_next();
    push_bit(1); push_bit(0); push_bit(1);
    step(1, 0, 0, 1, "pat4");
    chk("s20.ready", 256'(ready), 256'(1));
    chk("s20.state", 256'(state), 256'(2));
    chk("s20.in_comp", 256'(in_comp), 256'(4'b1011));
    chk("s20.counter", 256'(counter), 256'(20));
    chk("s20.head", 256'(stringo[0:19]), 256'(seq20));
    chk("s20.tail", 256'(stringo[20:39]), 256'(0));
    step(0, 0, 0, 0, "pat4_rel");

    // push and next are ignored in the ready phase
    push_bit(0);
    press_next();

    // roll_back together with push in the ready phase
    step(1, 0, 1, 1, "roll_push");
    chk("rp.counter", 256'(counter), 256'(0));
    chk("rp.stringo", 256'(stringo), 256'(0));
    chk("rp.in_comp", 256'(in_comp), 256'(0));
    chk("rp.ready", 256'(ready), 256'(0));
    chk("rp.state", 256'(state), 256'(0));
    step(0, 0, 0, 0, "roll_push_rel");

    // next too early sets err, which stays set after a legal next
    push_bit(1); push_bit(1); push_bit(0);
    press_next();
    chk("short.err", 256'(err), 256'(1));
    chk("short.state", 256'(state), 256'(0));
    chk("short.counter", 256'(counter), 256'(3));
    push_bit(1);
    press_next();
    chk("late.state", 256'(state), 256'(1));
    chk("late.err", 256'(err), 256'(1));
    press_roll();

    // fill to capacity, one extra push raises full
    for (int i = 0; i < ML; i++) push_bit(1);
    chk("cap.counter", 256'(counter), 256'(ML));
    chk("cap.full_before", 256'(full), 256'(0));
    push_bit(1);
    ones = '1;
    chk("cap.full", 256'(full), 256'(1));
    chk("cap.counter2", 256'(counter), 256'(ML));
    chk("cap.stringo", 256'(stringo), 256'(ones));
    // next with a coincident push at capacity: next wins, full unchanged
    step(1, 1, 0, 0, "push_next");
    chk("pn.state", 256'(state), 256'(1));
    step(0, 0, 0, 0, "push_next_rel");
    press_roll();

    // a held button counts once
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1, "hold");
    step(0, 0, 0, 0, "hold_rel");
    chk("hold.counter", 256'(counter), 256'(1));
    press_roll();

    // asynchronous reset mid pattern entry
    for (int i = 0; i < 5; i++) push_bit(1'(i % 2));
    press_next();
    push_bit(1); push_bit(1);
    @(negedge clk);
    #2 reset = 1'b0;
    model_clear();
    pp = 0; pn = 0; pr = 0;
    #1 compare_all("async_rst");
    chk("ar.state", 256'(state), 256'(0));
    chk("ar.in_comp", 256'(in_comp), 256'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    push_bit(1);
    chk("ar.restart", 256'(counter), 256'(1));

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)), "rand");
    end
    // long fill phase to reach capacity under random bits
    press_roll();
    for (int i = 0; i < ML + 3; i++) push_bit(1'($urandom_range(0, 1)));
    base = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'($urandom_range(0, 1)), 1'(i == 2), 1'b0, 1'($urandom_range(0, 1)), "rand_tail");
      base++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
